// File: rtl/dmem_dualwr_lanes.sv
// dmem_dualwr_lanes
// Data memory of DEPTH 32-bit words with two independent write ports and
// one synchronous read port.
// - Write ports A and C take byte, half or word stores with lane masking.
// - When A and C hit the same word, their lanes are merged and A wins on
//   any overlapping lane.
// - A post-reset sequencer fills every entry with INIT_VAL before the
//   ports are accepted.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   wr_en_a/addr_a/data_a/size_a  port A store request (size 00/01/10, 11 illegal)
//   wr_en_c/addr_c/data_c/size_c  port C store request, same encoding
//   rd_en/rd_addr/rd_size/rd_unsigned  load request, zero- or sign-extended
//   rd_data, rd_valid, rd_fault   registered load result, 1-cycle latency
//   wr_fault                   pulse when a store on A or C was rejected
//   init_busy                  high while the init sequencer runs
module dmem_dualwr_lanes #(
   parameter int          DEPTH    = 16,
   parameter int          ADDR_W   = 32,
   parameter logic [31:0] INIT_VAL = 32'h0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en_a,
   input  logic [ADDR_W-1:0] wr_addr_a,
   input  logic [31:0]       wr_data_a,
   input  logic [1:0]        wr_size_a,
   input  logic              wr_en_c,
   input  logic [ADDR_W-1:0] wr_addr_c,
   input  logic [31:0]       wr_data_c,
   input  logic [1:0]        wr_size_c,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [1:0]        rd_size,
   input  logic              rd_unsigned,
   output logic [31:0]       rd_data,
   output logic              rd_valid,
   output logic              rd_fault,
   output logic              wr_fault,
   output logic              init_busy
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [31:0]      mem [DEPTH];
   logic [IDX_W-1:0] init_cnt;

   // Misaligned, out-of-range (any bit above the word index) or illegal size.
   function automatic logic bad_req(input logic [ADDR_W-1:0] addr,
                                    input logic [1:0]        size);
      logic oor;
      logic mis;
      oor = |(addr >> (IDX_W + 2));
      case (size)
         2'b00:   mis = 1'b0;
         2'b01:   mis = addr[0];
         2'b10:   mis = |addr[1:0];
         default: mis = 1'b1;
      endcase
      return oor | mis;
   endfunction

   function automatic logic [31:0] put_lanes(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [1:0]  lo,
                                             input logic [1:0]  size);
      logic [31:0] w;
      w = old;
      case (size)
         2'b00:   w[{lo, 3'b000} +: 8]     = data[7:0];
         2'b01:   w[{lo[1], 4'b0000} +: 16] = data[15:0];
         default: w = data;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] word,
                                            input logic [1:0]  lo,
                                            input logic [1:0]  size,
                                            input logic        uns);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      b = word[{lo, 3'b000} +: 8];
      h = word[{lo[1], 4'b0000} +: 16];
      case (size)
         2'b00:   r = uns ? {24'd0, b} : 32'(b);
         2'b01:   r = uns ? {16'd0, h} : 32'(h);
         default: r = word;
      endcase
      return r;
   endfunction

   // ---- stage p0: request decode, lane merge and write-first bypass ----
   logic             idle_p0;
   logic             fault_a_p0, fault_c_p0, rd_bad_p0;
   logic             go_a_p0, go_c_p0, rd_go_p0;
   logic [IDX_W-1:0] idx_a_p0, idx_c_p0, idx_r_p0;
   logic [31:0]      word_a_p0, word_c_p0, rword_p0;

   always_comb begin
      idle_p0    = ~reset & ~init_busy;
      fault_a_p0 = bad_req(wr_addr_a, wr_size_a);
      fault_c_p0 = bad_req(wr_addr_c, wr_size_c);
      rd_bad_p0  = bad_req(rd_addr, rd_size);
      go_a_p0    = idle_p0 & wr_en_a & ~fault_a_p0;
      go_c_p0    = idle_p0 & wr_en_c & ~fault_c_p0;
      rd_go_p0   = idle_p0 & rd_en;
      idx_a_p0   = wr_addr_a[IDX_W+1:2];
      idx_c_p0   = wr_addr_c[IDX_W+1:2];
      idx_r_p0   = rd_addr[IDX_W+1:2];
      word_c_p0  = put_lanes(mem[idx_c_p0], wr_data_c, wr_addr_c[1:0], wr_size_c);
      // A is layered on top of C's result so A owns any shared lane.
      word_a_p0  = put_lanes((go_c_p0 && idx_c_p0 == idx_a_p0) ? word_c_p0 : mem[idx_a_p0],
                             wr_data_a, wr_addr_a[1:0], wr_size_a);
      // Write-first: word_a already carries C's lanes when both hit one entry.
      if (go_a_p0 && idx_a_p0 == idx_r_p0)
         rword_p0 = word_a_p0;
      else if (go_c_p0 && idx_c_p0 == idx_r_p0)
         rword_p0 = word_c_p0;
      else
         rword_p0 = mem[idx_r_p0];
   end

   // ---- stage p1: storage update and registered outputs ----
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (init_busy) begin
            mem[init_cnt] <= INIT_VAL;
         end else begin
            if (go_c_p0) mem[idx_c_p0] <= word_c_p0;
            if (go_a_p0) mem[idx_a_p0] <= word_a_p0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         init_busy <= 1'b1;
         init_cnt  <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         rd_fault  <= 1'b0;
         wr_fault  <= 1'b0;
      end else begin
         if (init_busy) begin
            if (init_cnt == IDX_W'(DEPTH - 1))
               init_busy <= 1'b0;
            else
               init_cnt <= init_cnt + 1'b1;
         end
         rd_valid <= rd_go_p0;
         rd_fault <= rd_go_p0 & rd_bad_p0;
         wr_fault <= idle_p0 & ((wr_en_a & fault_a_p0) | (wr_en_c & fault_c_p0));
         if (rd_go_p0)
            rd_data <= rd_bad_p0 ? 32'd0
                                 : load_ext(rword_p0, rd_addr[1:0], rd_size, rd_unsigned);
      end
   end

endmodule
